bg_rom_arbiter: RTL and testbench

- Shares the single background-ROM SDRAM channel between the three background layer engines.
- Each layer engine issues one single-cycle read request per 8-pixel tile row and expects one 32-bit word back.
- The block latches requests, grants them round-robin with one request in flight at a time, and routes `sdr_rdy`/`sdr_data` back to the issuing layer.
- It sits between the three layer instances and the SDRAM controller's background port.

---
 rtl/bg_rom_arbiter.sv | 118 +++++++++++
 tb/tb_bg_rom_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_rom_arbiter.sv
// Round-robin arbiter sharing the background-ROM SDRAM port
// between three layer engines, one read in flight at a time.
module bg_rom_arbiter #(
    parameter int ADDR_W  = 21,
    parameter int TIMEOUT = 63
) (
    input  logic                  CLK_32M,
    input  logic                  reset,
    input  logic [2:0]            layer_req,
    input  logic [3*ADDR_W-1:0]   layer_addr,
    output logic [2:0]            layer_rdy,
    output logic [95:0]           layer_data,
    output logic [ADDR_W-1:0]     sdr_addr,
    output logic                  sdr_req,
    input  logic                  sdr_rdy,
    input  logic [31:0]           sdr_data,
    output logic                  timeout_flag
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state, state_nx;
    logic [2:0]        pending;
    logic [ADDR_W-1:0] addr_q [3];
    logic [1:0]        grant, last_grant;
    logic [1:0]        pick, scan;
    logic              pick_vld;
    logic [7:0]        cnt;
    logic              expired;

    assign expired = (cnt == 8'(TIMEOUT - 1));

    // Scan starts one past the last served layer.
    always_comb begin
        pick     = 2'd0;
        pick_vld = 1'b0;
        scan     = last_grant;
        for (int k = 0; k < 3; k++) begin
            scan = (scan == 2'd2) ? 2'd0 : scan + 2'd1;
            if (!pick_vld && pending[scan]) begin
                pick     = scan;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (pick_vld) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (sdr_rdy || expired) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            pending      <= '0;
            grant        <= 2'd0;
            last_grant   <= 2'd2;
            cnt          <= '0;
            layer_rdy    <= '0;
            layer_data   <= '0;
            sdr_addr     <= '0;
            sdr_req      <= 1'b0;
            timeout_flag <= 1'b0;
            for (int i = 0; i < 3; i++) addr_q[i] <= '0;
        end else begin
            layer_rdy <= '0;
            sdr_req   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (layer_req[i]) begin
                    pending[i] <= 1'b1;
                    addr_q[i]  <= layer_addr[i*ADDR_W +: ADDR_W];
                end
            end
            unique case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant    <= pick;
                        sdr_req  <= 1'b1;
                        sdr_addr <= addr_q[pick];
                    end
                end
                ISSUE: begin
                    // A fresh strobe in this cycle keeps the layer pending.
                    if (!layer_req[grant]) pending[grant] <= 1'b0;
                    cnt <= '0;
                end
                WAIT: begin
                    if (sdr_rdy) begin
                        for (int i = 0; i < 3; i++) begin
                            if (grant == 2'(i)) begin
                                layer_data[i*32 +: 32] <= sdr_data;
                                layer_rdy[i]           <= 1'b1;
                            end
                        end
                        last_grant <= grant;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (expired) begin
                            timeout_flag <= 1'b1;
                            last_grant   <= grant;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bg_rom_arbiter.sv
// Directed bench for bg_rom_arbiter: ordering, overwrite,
// timeout and reset-abort behaviour.
module tb_bg_rom_arbiter;

    localparam int AW = 21;

    logic            CLK_32M;
    logic            reset;
    logic [2:0]      layer_req;
    logic [3*AW-1:0] layer_addr;
    logic [2:0]      layer_rdy;
    logic [95:0]     layer_data;
    logic [AW-1:0]   sdr_addr;
    logic            sdr_req;
    logic            sdr_rdy;
    logic [31:0]     sdr_data;
    logic            timeout_flag;

    int total = 0;
    int bad   = 0;
    logic [31:0]   exp_data [3];
    logic [AW-1:0] a;
    int            seen;

    bg_rom_arbiter #(.ADDR_W(AW), .TIMEOUT(63)) dut (
        .CLK_32M      (CLK_32M),
        .reset        (reset),
        .layer_req    (layer_req),
        .layer_addr   (layer_addr),
        .layer_rdy    (layer_rdy),
        .layer_data   (layer_data),
        .sdr_addr     (sdr_addr),
        .sdr_req      (sdr_req),
        .sdr_rdy      (sdr_rdy),
        .sdr_data     (sdr_data),
        .timeout_flag (timeout_flag)
    );

    initial CLK_32M = 1'b0;
    always #5 CLK_32M = ~CLK_32M;

    task automatic step();
        @(posedge CLK_32M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [2:0] m, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        layer_req  = m;
        layer_addr = {a2, a1, a0};
        step();
        layer_req  = 3'b000;
    endtask

    task automatic wait_req(output logic [AW-1:0] addr);
        int n = 0;
        while (sdr_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", {95'd0, sdr_req}, 96'd1);
        addr = sdr_addr;
    endtask

    // From the ISSUE cycle: lat cycles of silence, then one sdr_rdy.
    task automatic respond(input int lat, input logic [31:0] d);
        step();
        chk("req_single", {95'd0, sdr_req}, 96'd0);
        for (int i = 1; i < lat; i++) step();
        sdr_rdy  = 1'b1;
        sdr_data = d;
        step();
        sdr_rdy  = 1'b0;
        sdr_data = 32'h0;
    endtask

    function automatic logic [95:0] exp_bus();
        return {exp_data[2], exp_data[1], exp_data[0]};
    endfunction

    initial begin
        reset      = 1'b1;
        layer_req  = 3'b000;
        layer_addr = '0;
        sdr_rdy    = 1'b0;
        sdr_data   = 32'h0;
        for (int i = 0; i < 3; i++) exp_data[i] = 32'h0;
        step();
        step();
        chk("rst_rdy", {93'd0, layer_rdy}, 96'd0);
        chk("rst_data", layer_data, 96'd0);
        chk("rst_req", {95'd0, sdr_req}, 96'd0);
        chk("rst_addr", {75'd0, sdr_addr}, 96'd0);
        chk("rst_tmo", {95'd0, timeout_flag}, 96'd0);
        reset = 1'b0;
        step();

        // Simultaneous: order 0,1,2 from reset priority
        pulse(3'b111, 21'h00010, 21'h00020, 21'h00030);
        wait_req(a);
        chk("sim0_addr", {75'd0, a}, 96'h10);
        respond(4, 32'hA0A0A0A0);
        exp_data[0] = 32'hA0A0A0A0;
        chk("sim0_rdy", {93'd0, layer_rdy}, 96'b001);
        chk("sim0_data", layer_data, exp_bus());
        wait_req(a);
        chk("sim1_addr", {75'd0, a}, 96'h20);
        respond(4, 32'hB1B1B1B1);
        exp_data[1] = 32'hB1B1B1B1;
        chk("sim1_rdy", {93'd0, layer_rdy}, 96'b010);
        chk("sim1_data", layer_data, exp_bus());
        wait_req(a);
        chk("sim2_addr", {75'd0, a}, 96'h30);
        respond(4, 32'hC2C2C2C2);
        exp_data[2] = 32'hC2C2C2C2;
        chk("sim2_rdy", {93'd0, layer_rdy}, 96'b100);
        chk("sim2_data", layer_data, exp_bus());
        step();
        chk("sim_rdy_drop", {93'd0, layer_rdy}, 96'd0);

        // Single request, exact latency
        pulse(3'b001, 21'h01234, 21'h0, 21'h0);
        chk("one_t1_req", {95'd0, sdr_req}, 96'd0);
        step();
        chk("one_t2_req", {95'd0, sdr_req}, 96'd1);
        chk("one_addr", {75'd0, sdr_addr}, 96'h01234);
        respond(3, 32'hDEADBEEF);
        exp_data[0] = 32'hDEADBEEF;
        chk("one_rdy", {93'd0, layer_rdy}, 96'b001);
        chk("one_data", layer_data, exp_bus());
        step();
        chk("one_rdy_drop", {93'd0, layer_rdy}, 96'd0);
        chk("one_hold", layer_data, exp_bus());

        // Round-robin after serving layer 1
        pulse(3'b010, 21'h0, 21'h00555, 21'h0);
        wait_req(a);
        chk("rr_prep_addr", {75'd0, a}, 96'h555);
        respond(2, 32'h11111111);
        exp_data[1] = 32'h11111111;
        chk("rr_prep_rdy", {93'd0, layer_rdy}, 96'b010);
        pulse(3'b101, 21'h00600, 21'h0, 21'h00700);
        wait_req(a);
        chk("rr_first", {75'd0, a}, 96'h700);
        respond(2, 32'h22222222);
        exp_data[2] = 32'h22222222;
        chk("rr_first_rdy", {93'd0, layer_rdy}, 96'b100);
        wait_req(a);
        chk("rr_second", {75'd0, a}, 96'h600);
        respond(2, 32'h33333333);
        exp_data[0] = 32'h33333333;
        chk("rr_second_rdy", {93'd0, layer_rdy}, 96'b001);
        chk("rr_data", layer_data, exp_bus());

        // Overwrite while layer 0 is in flight
        pulse(3'b001, 21'h000AA, 21'h0, 21'h0);
        wait_req(a);
        chk("ow_l0_addr", {75'd0, a}, 96'hAA);
        pulse(3'b010, 21'h0, 21'h00100, 21'h0);
        pulse(3'b010, 21'h0, 21'h00200, 21'h0);
        respond(1, 32'h44444444);
        exp_data[0] = 32'h44444444;
        chk("ow_l0_rdy", {93'd0, layer_rdy}, 96'b001);
        wait_req(a);
        chk("ow_l1_addr", {75'd0, a}, 96'h200);
        respond(1, 32'h55555555);
        exp_data[1] = 32'h55555555;
        chk("ow_l1_rdy", {93'd0, layer_rdy}, 96'b010);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (sdr_req === 1'b1) seen++;
        end
        chk("ow_single_fetch", 96'(seen), 96'd0);

        // Timeout on layer 2, then layer 0 served
        pulse(3'b101, 21'h00333, 21'h0, 21'h02222);
        wait_req(a);
        chk("to_addr", {75'd0, a}, 96'h2222);
        seen = 0;
        for (int i = 0; i < 63; i++) begin
            step();
            if (layer_rdy !== 3'b000 || timeout_flag !== 1'b0 ||
                sdr_req !== 1'b0) seen++;
        end
        chk("to_quiet_wait", 96'(seen), 96'd0);
        step();
        chk("to_flag", {95'd0, timeout_flag}, 96'd1);
        chk("to_no_rdy", {93'd0, layer_rdy}, 96'd0);
        step();
        chk("to_next_req", {95'd0, sdr_req}, 96'd1);
        chk("to_next_addr", {75'd0, sdr_addr}, 96'h333);
        sdr_rdy  = 1'b1;
        sdr_data = 32'hFFFFFFFF;
        step();
        sdr_rdy  = 1'b0;
        sdr_data = 32'h0;
        step();
        chk("to_stray", {93'd0, layer_rdy}, 96'd0);
        chk("to_stray_data", layer_data, exp_bus());
        sdr_rdy  = 1'b1;
        sdr_data = 32'h0BADF00D;
        step();
        sdr_rdy  = 1'b0;
        exp_data[0] = 32'h0BADF00D;
        chk("to_l0_rdy", {93'd0, layer_rdy}, 96'b001);
        chk("to_l0_data", layer_data, exp_bus());
        chk("to_sticky", {95'd0, timeout_flag}, 96'd1);

        // Reset during WAIT for layer 0
        pulse(3'b001, 21'h00444, 21'h0, 21'h0);
        wait_req(a);
        chk("rw_addr", {75'd0, a}, 96'h444);
        step();
        step();
        #2 reset = 1'b1;
        #1;
        chk("rw_rdy", {93'd0, layer_rdy}, 96'd0);
        chk("rw_data", layer_data, 96'd0);
        chk("rw_req", {95'd0, sdr_req}, 96'd0);
        chk("rw_sdr_addr", {75'd0, sdr_addr}, 96'd0);
        chk("rw_tmo", {95'd0, timeout_flag}, 96'd0);
        for (int i = 0; i < 3; i++) exp_data[i] = 32'h0;
        step();
        reset = 1'b0;
        sdr_rdy  = 1'b1;
        sdr_data = 32'h66666666;
        step();
        sdr_rdy  = 1'b0;
        sdr_data = 32'h0;
        step();
        chk("rw_late_rdy", {93'd0, layer_rdy}, 96'd0);
        chk("rw_late_req", {95'd0, sdr_req}, 96'd0);
        pulse(3'b111, 21'h00801, 21'h00802, 21'h00803);
        wait_req(a);
        chk("rw_first_grant", {75'd0, a}, 96'h801);
        respond(2, 32'h77777777);
        exp_data[0] = 32'h77777777;
        chk("rw_l0_rdy", {93'd0, layer_rdy}, 96'b001);
        chk("rw_l0_data", layer_data, exp_bus());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
